// File: rtl/mem_rd_stream_if.sv
// Producer/consumer-facing signals of the message-memory read streamer.
// The slave modport is the streamer; the master modport is its environment.
interface mem_rd_stream_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);
  logic                  push;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  full;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH:0]   count;
  logic                  flush;
  logic                  ovf;

  modport slave (
    input  push, rd_data, out_ready, flush,
    output wr_addr, full, rd_addr, out_valid, out_data, count, ovf
  );

  modport master (
    output push, rd_data, out_ready, flush,
    input  wr_addr, full, rd_addr, out_valid, out_data, count, ovf
  );
endinterface

// File: rtl/mem_rd_stream.sv
// Circular-buffer pointer owner for an async-read message memory; streams
// stored words out through a registered valid/ready output stage.
module mem_rd_stream #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_rd_stream_if.slave  bus
);
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);

  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   count, count_next;
  logic                  out_valid, ovf;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  full, push_acc, load;

  // Full looks only at the current count, so a push racing a load from a
  // full buffer is still dropped.
  assign full     = (count == DEPTH_CNT);
  assign push_acc = bus.push && !full;
  assign load     = (count != '0) && (!out_valid || bus.out_ready);

  always_comb begin
    count_next = count;
    case ({push_acc, load})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      ovf       <= 1'b0;
    end else if (bus.flush) begin
      // out_data deliberately keeps its last value across a flush
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (push_acc)           wr_ptr <= wr_ptr + 1'b1;
      if (bus.push && full)   ovf    <= 1'b1;
      if (load) begin
        out_data  <= bus.rd_data;
        out_valid <= 1'b1;
        rd_ptr    <= rd_ptr + 1'b1;
      end else if (out_valid && bus.out_ready) begin
        out_valid <= 1'b0;
      end
      count <= count_next;
    end
  end

  assign bus.wr_addr   = wr_ptr;
  assign bus.rd_addr   = rd_ptr;
  assign bus.full      = full;
  assign bus.count     = count;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.ovf       = ovf;
endmodule

// File: doc/mem_rd_stream.md
# mem_rd_stream

Read-side controller for the single-write, async-read dual-port message memory used in the fan-in/fan-out path. It owns both the write and read pointers as a circular buffer. It hands the write address to the producer and drives the memory read port itself. It streams stored words out through a registered valid/ready interface to the downstream router stage.

## Interface
Parameters:
- ADDR_WIDTH, default 4: memory address width. Depth DEPTH = 2^ADDR_WIDTH.
- DATA_WIDTH, default 32: memory word width.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- push, input, 1: producer wrote mem[wr_addr] this cycle (its write-enable qualified by chip-select).
- wr_addr, output, ADDR_WIDTH: address the producer must drive on the memory write port.
- full, output, 1: no free memory entry. The producer must not push.
- rd_addr, output, ADDR_WIDTH: drives the memory read-port address.
- rd_data, input, DATA_WIDTH: memory read-port data, combinational from rd_addr.
- out_valid, output, 1: out_data holds a word.
- out_ready, input, 1: downstream accepts the word when out_valid && out_ready.
- out_data, output, DATA_WIDTH: registered output word.
- count, output, ADDR_WIDTH+1: words in memory not yet loaded into out_data.
- flush, input, 1: synchronous clear of all state.
- ovf, output, 1: sticky flag. A push arrived while full.

## Operation
- State: wr_ptr, rd_ptr (ADDR_WIDTH, wrap mod DEPTH), count (0..DEPTH), out_valid/out_data register, ovf.
- wr_addr = wr_ptr. rd_addr = rd_ptr. full = (count == DEPTH). All three are combinational from registered state only.
- push_acc = push && !full. On push_acc, wr_ptr increments.
- A push while full is dropped: pointers and count are unchanged, and ovf is set.
- load = (count != 0) && (!out_valid || out_ready). On load, out_data <= rd_data, out_valid <= 1, and rd_ptr increments.
- If out_valid && out_ready && !load, out_valid <= 0. out_data holds its last value.
- count_next = count + push_acc - load. A simultaneous push_acc and load leaves count unchanged.
- full is evaluated on the current count. A push in the same cycle as a load from a full buffer is still dropped.
- Total buffering is DEPTH memory entries plus 1 output register.
- flush (has priority over push, load, and handshake): wr_ptr, rd_ptr, count <= 0; out_valid <= 0; ovf <= 0. Any push in the flush cycle is ignored and does not set ovf. out_data is unchanged.
- Reset (rst_n low, any time, including mid-stream): wr_ptr, rd_ptr, count, out_valid, out_data, and ovf all go to 0.

## Timing
- Write-to-output latency: push in cycle N (memory written at the end of N, count incremented) → load at the end of N+1 → out_valid high in cycle N+2.
- Throughput: with out_ready held high and count > 0, one word per cycle.
- Backpressure: out_valid and out_data stay stable while !out_ready. No load occurs.
- Reset release: first push is accepted in the first cycle rst_n is sampled high.
- No combinational path from out_ready or push to any output.

## Test plan
- Reset/idle: assert rst_n=0 mid-stream with count=5 and out_valid=1 → all outputs 0 immediately. After release, wr_addr=0, full=0.
- Single word: push 0xDEADBEEF at addr 0 in cycle N with out_ready=1 → out_valid=1 and out_data=0xDEADBEEF in cycle N+2 only. count goes 1 then 0. rd_addr=1 afterward.
- Fill/full/overflow (ADDR_WIDTH=4): push 17 words with out_ready=0 → first word in out_data, count=16, full=1. A 18th push is dropped and ovf=1. Drain yields the 17 words in order.
- Streaming wrap: 40 back-to-back pushes with out_ready=1 → 40 words out in order, one per cycle after 2-cycle latency. Pointers wrap through 15→0 twice. count never exceeds 1.
- Random backpressure: random push and out_ready (50%) for 2000 cycles → scoreboard order matches and no loss. The out_data hold rule is checked while !out_ready. Overflow never occurs when the producer honours full.
- Flush: with count=7 and out_valid=1, assert flush together with push → next cycle count=0, out_valid=0, ovf=0, wr_addr=0, rd_addr=0. The pushed word is not delivered.
